// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_pkg - exception flag layout, ExcCodes and FSM states for wb_commit      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package wb_pkg;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    localparam int EXC_BIT_INT  = 0;
    localparam int EXC_BIT_ADEL = 4;
    localparam int EXC_BIT_ADES = 5;
    localparam int EXC_BIT_SYS  = 8;
    localparam int EXC_BIT_BP   = 9;
    localparam int EXC_BIT_RI   = 10;
    localparam int EXC_BIT_OV   = 12;
    localparam int EXC_BIT_ERET = 13;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WAIT  = 2'd2
    } wb_state_t;

    // Lowest-numbered flag wins.
    function automatic logic [4:0] exc_code_of(input logic [31:0] etype);
        if (etype[EXC_BIT_INT])       return EXCCODE_INT;
        else if (etype[EXC_BIT_ADEL]) return EXCCODE_ADEL;
        else if (etype[EXC_BIT_ADES]) return EXCCODE_ADES;
        else if (etype[EXC_BIT_SYS])  return EXCCODE_SYS;
        else if (etype[EXC_BIT_BP])   return EXCCODE_BP;
        else if (etype[EXC_BIT_RI])   return EXCCODE_RI;
        else if (etype[EXC_BIT_OV])   return EXCCODE_OV;
        else                          return EXCCODE_INT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_commit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_commit_if - registered W-stage bundle from the MEM->WB pipeline register|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface wb_commit_if;
    logic        RegWriteW;
    logic        MemToRegW;
    logic [31:0] ReadDataW;
    logic [31:0] ResultW;
    logic [4:0]  WriteRegW;
    logic [1:0]  HiLoWriteW;
    logic [31:0] HiInW;
    logic [31:0] LoInW;
    logic        CP0WriteW;
    logic [4:0]  WriteCP0AddrW;
    logic [2:0]  WriteCP0SelW;
    logic [31:0] WriteCP0HiLoDataW;
    logic [31:0] PCW;
    logic        InDelaySlotW;
    logic [31:0] BadVAddrW;
    logic [31:0] ExceptionTypeW;

    modport master (
        output RegWriteW, MemToRegW, ReadDataW, ResultW, WriteRegW,
               HiLoWriteW, HiInW, LoInW,
               CP0WriteW, WriteCP0AddrW, WriteCP0SelW, WriteCP0HiLoDataW,
               PCW, InDelaySlotW, BadVAddrW, ExceptionTypeW
    );

    modport slave (
        input  RegWriteW, MemToRegW, ReadDataW, ResultW, WriteRegW,
               HiLoWriteW, HiInW, LoInW,
               CP0WriteW, WriteCP0AddrW, WriteCP0SelW, WriteCP0HiLoDataW,
               PCW, InDelaySlotW, BadVAddrW, ExceptionTypeW
    );
endinterface
`default_nettype wire

// File: rtl/wb_commit_hilo_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hilo_reg - HI/LO pair with per-half enables; WB_HILO_BYPASS_EN forwards    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hilo_reg (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [1:0]  we,
    input  wire logic [31:0] hi_in,
    input  wire logic [31:0] lo_in,
    output logic      [31:0] hi,
    output logic      [31:0] lo
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (we[1]) r_hi <= hi_in;
            if (we[0]) r_lo <= lo_in;
        end
    end

`ifdef WB_HILO_BYPASS_EN
    // Same-cycle forwarding lets an MFHI/MFLO right behind the writer see it.
    assign hi = we[1] ? hi_in : r_hi;
    assign lo = we[0] ? lo_in : r_lo;
`else
    assign hi = r_hi;
    assign lo = r_lo;
`endif

endmodule
`default_nettype wire

// File: rtl/wb_commit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_commit - W-stage commit: GPR/HI/LO/CP0 updates, exception/ERET redirect |
// | Revision: 1.0   (optional macro: WB_HILO_BYPASS_EN)                        |
// +----------------------------------------------------------------------------+
module wb_commit
    import wb_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          ERET_BIT   = EXC_BIT_ERET
) (
    input  wire logic        clk,
    input  wire logic        rst,
    wb_commit_if.slave       wb,
    input  wire logic [31:0] cp0_epc_i,
    input  wire logic        redirect_ready_i,
    output logic             rf_we_o,
    output logic      [4:0]  rf_waddr_o,
    output logic      [31:0] rf_wdata_o,
    output logic      [31:0] hi_o,
    output logic      [31:0] lo_o,
    output logic             cp0_we_o,
    output logic      [4:0]  cp0_addr_o,
    output logic      [2:0]  cp0_sel_o,
    output logic      [31:0] cp0_wdata_o,
    output logic             exc_we_o,
    output logic      [4:0]  exc_code_o,
    output logic      [31:0] exc_epc_o,
    output logic             exc_bd_o,
    output logic      [31:0] exc_badvaddr_o,
    output logic             eret_o,
    output logic             flush_o,
    output logic             redirect_valid_o,
    output logic      [31:0] redirect_pc_o
);

    wb_state_t   r_state;
    wb_state_t   w_state_nxt;

    logic [31:0] w_eret_mask;
    logic        w_exc;
    logic        w_eret;
    logic        w_idle;
    logic        w_commit_ok;
    logic        w_trap;

    logic        r_is_exc;
    logic [4:0]  r_exc_code;
    logic [31:0] r_exc_epc;
    logic        r_exc_bd;
    logic [31:0] r_exc_badvaddr;
    logic [31:0] r_redirect_pc;

    assign w_eret_mask = 32'd1 << ERET_BIT;
    assign w_exc       = |(wb.ExceptionTypeW & ~w_eret_mask);
    assign w_eret      = wb.ExceptionTypeW[ERET_BIT];
    assign w_idle      = (r_state == ST_IDLE);
    // rst is folded in so every output reads 0 while reset is held.
    assign w_commit_ok = rst && w_idle && !w_exc && !w_eret;
    assign w_trap      = w_idle && (w_exc || w_eret);

    assign rf_we_o     = wb.RegWriteW && w_commit_ok && (wb.WriteRegW != 5'd0);
    assign rf_waddr_o  = rst ? wb.WriteRegW : 5'd0;
    assign rf_wdata_o  = !rst ? 32'd0 : (wb.MemToRegW ? wb.ReadDataW : wb.ResultW);

    assign cp0_we_o    = wb.CP0WriteW && w_commit_ok;
    assign cp0_addr_o  = rst ? wb.WriteCP0AddrW : 5'd0;
    assign cp0_sel_o   = rst ? wb.WriteCP0SelW : 3'd0;
    assign cp0_wdata_o = rst ? wb.WriteCP0HiLoDataW : 32'd0;

    hilo_reg u_hilo (
        .clk   (clk),
        .rst   (rst),
        .we    (wb.HiLoWriteW & {2{w_commit_ok}}),
        .hi_in (wb.HiInW),
        .lo_in (wb.LoInW),
        .hi    (hi_o),
        .lo    (lo_o)
    );

    // Trap fields are captured on the edge that leaves IDLE; an ERET only
    // replaces the redirect target and leaves the exception fields alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_exc       <= 1'b0;
            r_exc_code     <= '0;
            r_exc_epc      <= '0;
            r_exc_bd       <= 1'b0;
            r_exc_badvaddr <= '0;
            r_redirect_pc  <= '0;
        end else if (w_trap) begin
            r_is_exc <= w_exc;
            if (w_exc) begin
                r_exc_code     <= exc_code_of(wb.ExceptionTypeW);
                r_exc_epc      <= wb.InDelaySlotW ? (wb.PCW - 32'd4) : wb.PCW;
                r_exc_bd       <= wb.InDelaySlotW;
                r_exc_badvaddr <= wb.BadVAddrW;
                r_redirect_pc  <= EXC_VECTOR;
            end else begin
                r_redirect_pc  <= cp0_epc_i;
            end
        end
    end

    assign exc_code_o     = r_exc_code;
    assign exc_epc_o      = r_exc_epc;
    assign exc_bd_o       = r_exc_bd;
    assign exc_badvaddr_o = r_exc_badvaddr;
    assign redirect_pc_o  = r_redirect_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_exc || w_eret) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = redirect_ready_i ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (redirect_ready_i) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        flush_o          = 1'b0;
        exc_we_o         = 1'b0;
        eret_o           = 1'b0;
        redirect_valid_o = 1'b0;
        case (r_state)
            ST_FLUSH: begin
                flush_o          = 1'b1;
                exc_we_o         = r_is_exc;
                eret_o           = !r_is_exc;
                redirect_valid_o = 1'b1;
            end
            ST_WAIT:  redirect_valid_o = 1'b1;
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_commit - randomized scoreboard bench for wb_commit                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wb_commit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cp0_epc_i;
    logic        redirect_ready_i;

    logic        rf_we_o, cp0_we_o, exc_we_o, exc_bd_o, eret_o, flush_o, redirect_valid_o;
    logic [4:0]  rf_waddr_o, cp0_addr_o, exc_code_o;
    logic [2:0]  cp0_sel_o;
    logic [31:0] rf_wdata_o, hi_o, lo_o, cp0_wdata_o, exc_epc_o, exc_badvaddr_o, redirect_pc_o;

    wb_commit_if wb ();

    wb_commit dut (
        .clk              (clk),
        .rst              (rst),
        .wb               (wb),
        .cp0_epc_i        (cp0_epc_i),
        .redirect_ready_i (redirect_ready_i),
        .rf_we_o          (rf_we_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .hi_o             (hi_o),
        .lo_o             (lo_o),
        .cp0_we_o         (cp0_we_o),
        .cp0_addr_o       (cp0_addr_o),
        .cp0_sel_o        (cp0_sel_o),
        .cp0_wdata_o      (cp0_wdata_o),
        .exc_we_o         (exc_we_o),
        .exc_code_o       (exc_code_o),
        .exc_epc_o        (exc_epc_o),
        .exc_bd_o         (exc_bd_o),
        .exc_badvaddr_o   (exc_badvaddr_o),
        .eret_o           (eret_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        cp0_we;
        logic [4:0]  cp0_addr;
        logic [2:0]  cp0_sel;
        logic [31:0] cp0_wdata;
        logic        exc_we;
        logic [4:0]  exc_code;
        logic [31:0] exc_epc;
        logic        exc_bd;
        logic [31:0] exc_badvaddr;
        logic        eret;
        logic        flush;
        logic        rvalid;
        logic [31:0] rpc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a pending redirect either still owes its one-cycle
    // flush pulse (m_first) or is just waiting for fetch to accept it.
    logic [31:0] m_hi, m_lo, m_epc, m_badv, m_rpc;
    logic [4:0]  m_code;
    logic        m_busy, m_first, m_is_exc, m_bd;
    int          prio[7] = '{0, 4, 5, 8, 9, 10, 12};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        m_hi = 0; m_lo = 0; m_epc = 0; m_badv = 0; m_rpc = 0; m_code = 0;
        m_busy = 0; m_first = 0; m_is_exc = 0; m_bd = 0;
    endtask

    task automatic eval();
        exp_t        e;
        logic        x, er, ok, found;
        logic [31:0] et;
        e  = '0;
        if (!rst) begin
            model_clear();
            q.push_back(e);
            return;
        end
        et = wb.ExceptionTypeW;
        x  = (et & ~(32'd1 << 13)) != 32'd0;
        er = et[13];
        ok = !m_busy && !x && !er;
        e.rf_we        = wb.RegWriteW && ok && (wb.WriteRegW != 0);
        e.rf_waddr     = wb.WriteRegW;
        e.rf_wdata     = wb.MemToRegW ? wb.ReadDataW : wb.ResultW;
        e.cp0_we       = wb.CP0WriteW && ok;
        e.cp0_addr     = wb.WriteCP0AddrW;
        e.cp0_sel      = wb.WriteCP0SelW;
        e.cp0_wdata    = wb.WriteCP0HiLoDataW;
        e.hi           = m_hi;
        e.lo           = m_lo;
`ifdef WB_HILO_BYPASS_EN
        if (ok && wb.HiLoWriteW[1]) e.hi = wb.HiInW;
        if (ok && wb.HiLoWriteW[0]) e.lo = wb.LoInW;
`endif
        e.exc_code     = m_code;
        e.exc_epc      = m_epc;
        e.exc_bd       = m_bd;
        e.exc_badvaddr = m_badv;
        e.flush        = m_busy && m_first;
        e.exc_we       = m_busy && m_first && m_is_exc;
        e.eret         = m_busy && m_first && !m_is_exc;
        e.rvalid       = m_busy;
        e.rpc          = m_rpc;
        q.push_back(e);

        if (ok) begin
            if (wb.HiLoWriteW[1]) m_hi = wb.HiInW;
            if (wb.HiLoWriteW[0]) m_lo = wb.LoInW;
        end
        if (!m_busy && (x || er)) begin
            m_busy   = 1;
            m_first  = 1;
            m_is_exc = x;
            if (x) begin
                found = 0;
                foreach (prio[i]) if (!found && et[prio[i]]) begin
                    m_code = 5'(prio[i]);
                    found  = 1;
                end
                m_epc  = wb.InDelaySlotW ? wb.PCW - 32'd4 : wb.PCW;
                m_bd   = wb.InDelaySlotW;
                m_badv = wb.BadVAddrW;
                m_rpc  = 32'hBFC0_0380;
            end else begin
                m_rpc  = cp0_epc_i;
            end
        end else if (m_busy) begin
            m_first = 0;
            if (redirect_ready_i) m_busy = 0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rf_we",        32'(rf_we_o),          32'(e.rf_we));
            chk("rf_waddr",     32'(rf_waddr_o),       32'(e.rf_waddr));
            chk("rf_wdata",     rf_wdata_o,            e.rf_wdata);
            chk("hi",           hi_o,                  e.hi);
            chk("lo",           lo_o,                  e.lo);
            chk("cp0_we",       32'(cp0_we_o),         32'(e.cp0_we));
            chk("cp0_addr",     32'(cp0_addr_o),       32'(e.cp0_addr));
            chk("cp0_sel",      32'(cp0_sel_o),        32'(e.cp0_sel));
            chk("cp0_wdata",    cp0_wdata_o,           e.cp0_wdata);
            chk("exc_we",       32'(exc_we_o),         32'(e.exc_we));
            chk("eret",         32'(eret_o),           32'(e.eret));
            chk("flush",        32'(flush_o),          32'(e.flush));
            chk("redirect_vld", 32'(redirect_valid_o), 32'(e.rvalid));
            if (e.rvalid || !rst) begin
                chk("redirect_pc", redirect_pc_o, e.rpc);
            end
            if (e.exc_we || !rst) begin
                chk("exc_code",     32'(exc_code_o), 32'(e.exc_code));
                chk("exc_epc",      exc_epc_o,       e.exc_epc);
                chk("exc_bd",       32'(exc_bd_o),   32'(e.exc_bd));
                chk("exc_badvaddr", exc_badvaddr_o,  e.exc_badvaddr);
            end
        end
    end

    task automatic idle_inputs();
        wb.RegWriteW = 0; wb.MemToRegW = 0; wb.ReadDataW = 0; wb.ResultW = 0;
        wb.WriteRegW = 0; wb.HiLoWriteW = 0; wb.HiInW = 0; wb.LoInW = 0;
        wb.CP0WriteW = 0; wb.WriteCP0AddrW = 0; wb.WriteCP0SelW = 0;
        wb.WriteCP0HiLoDataW = 0; wb.PCW = 0; wb.InDelaySlotW = 0;
        wb.BadVAddrW = 0; wb.ExceptionTypeW = 0;
        cp0_epc_i = 0; redirect_ready_i = 1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        int r;
        wb.RegWriteW = 1'($urandom); wb.MemToRegW = 1'($urandom);
        wb.ReadDataW = $urandom; wb.ResultW = $urandom; wb.WriteRegW = 5'($urandom);
        wb.HiLoWriteW = 2'($urandom); wb.HiInW = $urandom; wb.LoInW = $urandom;
        wb.CP0WriteW = 1'($urandom); wb.WriteCP0AddrW = 5'($urandom);
        wb.WriteCP0SelW = 3'($urandom); wb.WriteCP0HiLoDataW = $urandom;
        wb.PCW = $urandom; wb.InDelaySlotW = 1'($urandom); wb.BadVAddrW = $urandom;
        cp0_epc_i = $urandom;
        redirect_ready_i = ($urandom_range(0, 2) != 0);
        r = $urandom_range(0, 11);
        case (r)
            0: wb.ExceptionTypeW = 32'd1 << 13;
            1, 2: begin
                wb.ExceptionTypeW = $urandom & 32'h0000_1731;
                if (wb.ExceptionTypeW == 0) wb.ExceptionTypeW = 32'd1 << 12;
                if (r == 2) wb.ExceptionTypeW[13] = 1'b1;
            end
            default: wb.ExceptionTypeW = 0;
        endcase
    endtask

    initial begin
        model_clear();
        idle_inputs();
        rst = 0;
        // Reset held for a few cycles, with garbage commits that must stay gated.
        repeat (3) begin
            next_cycle();
            rand_inputs();
            eval();
        end
        next_cycle();
        idle_inputs();
        rst = 1;
        eval();

        // Load commit and x0 write.
        next_cycle();
        wb.RegWriteW = 1; wb.MemToRegW = 1; wb.WriteRegW = 5; wb.ReadDataW = 32'hDEADBEEF;
        eval();
        @(negedge clk);
        chk("load_we", 32'(rf_we_o), 32'd1);
        chk("load_data", rf_wdata_o, 32'hDEADBEEF);
        next_cycle();
        wb.WriteRegW = 0;
        eval();
        @(negedge clk);
        chk("x0_we", 32'(rf_we_o), 32'd0);

        // HI/LO writes.
        next_cycle();
        idle_inputs();
        wb.HiLoWriteW = 2'b11; wb.HiInW = 1; wb.LoInW = 2;
        eval();
        next_cycle();
        wb.HiLoWriteW = 2'b01; wb.HiInW = 99; wb.LoInW = 7;
        eval();
        @(negedge clk);
        chk("hilo_hi1", hi_o, 32'd1);
        next_cycle();
        idle_inputs();
        eval();
        @(negedge clk);
        chk("hilo_hi2", hi_o, 32'd1);
        chk("hilo_lo2", lo_o, 32'd7);

        // Overflow in a delay slot.
        next_cycle();
        wb.ExceptionTypeW = 32'd1 << 12; wb.PCW = 32'h8000_0104;
        wb.InDelaySlotW = 1; wb.RegWriteW = 1; wb.WriteRegW = 9;
        eval();
        @(negedge clk);
        chk("ovf_rf_we", 32'(rf_we_o), 32'd0);
        next_cycle();
        idle_inputs();
        eval();
        @(negedge clk);
        chk("ovf_flush", 32'(flush_o), 32'd1);
        chk("ovf_exc_we", 32'(exc_we_o), 32'd1);
        chk("ovf_code", 32'(exc_code_o), 32'd12);
        chk("ovf_epc", exc_epc_o, 32'h8000_0100);
        chk("ovf_bd", 32'(exc_bd_o), 32'd1);
        chk("ovf_rpc", redirect_pc_o, 32'hBFC0_0380);

        // Handshake stall with wrong-path commits and a wrong-path exception.
        next_cycle();
        wb.ExceptionTypeW = 32'd1 << 8; wb.PCW = 32'h8000_0040; redirect_ready_i = 0;
        eval();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            idle_inputs();
            wb.RegWriteW = 1; wb.WriteRegW = 5'(3 + i); wb.CP0WriteW = 1;
            wb.HiLoWriteW = 2'b11; wb.HiInW = 32'h55; wb.LoInW = 32'h66;
            if (i == 1) wb.ExceptionTypeW = 32'd1 << 10;
            redirect_ready_i = (i == 3);
            eval();
            @(negedge clk);
            chk("stall_rvalid", 32'(redirect_valid_o), 32'd1);
            chk("stall_flush", 32'(flush_o), (i == 0) ? 32'd1 : 32'd0);
            chk("stall_rf_we", 32'(rf_we_o), 32'd0);
        end

        // ERET.
        next_cycle();
        idle_inputs();
        wb.ExceptionTypeW = 32'd1 << 13; cp0_epc_i = 32'h8000_0200;
        eval();
        next_cycle();
        idle_inputs();
        eval();
        @(negedge clk);
        chk("eret_pulse", 32'(eret_o), 32'd1);
        chk("eret_flush", 32'(flush_o), 32'd1);
        chk("eret_rpc", redirect_pc_o, 32'h8000_0200);
        next_cycle();
        wb.RegWriteW = 1; wb.WriteRegW = 7;
        eval();
        @(negedge clk);
        chk("eret_idle_we", 32'(rf_we_o), 32'd1);

        // Priority: AdEL over Ov.
        next_cycle();
        idle_inputs();
        wb.ExceptionTypeW = (32'd1 << 4) | (32'd1 << 12);
        eval();
        next_cycle();
        idle_inputs();
        eval();
        @(negedge clk);
        chk("prio_code", 32'(exc_code_o), 32'd4);

        // Async reset while waiting on the redirect handshake.
        next_cycle();
        wb.ExceptionTypeW = 32'd1 << 5; redirect_ready_i = 0;
        eval();
        next_cycle();
        idle_inputs();
        redirect_ready_i = 0;
        eval();
        next_cycle();
        redirect_ready_i = 0;
        rst = 0;
        eval();
        #1;
        chk("rst_rvalid", 32'(redirect_valid_o), 32'd0);
        chk("rst_rpc", redirect_pc_o, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        next_cycle();
        eval();
        next_cycle();
        rst = 1;
        redirect_ready_i = 1;
        wb.RegWriteW = 1; wb.WriteRegW = 4;
        eval();
        @(negedge clk);
        chk("rst_idle_we", 32'(rf_we_o), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            next_cycle();
            rand_inputs();
            eval();
        end
        next_cycle();
        idle_inputs();
        eval();

        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
